// File: rtl/rat_if.sv
// rat_if: rename, CDB, checkpoint and resolve signals between the rename stage and the alias table.
interface rat_if #(
  parameter int ARCH_IDX     = 4,
  parameter int PHYS_IDX     = 5,
  parameter int RENAME_WIDTH = 2,
  parameter int NUM_CDB      = 2,
  parameter int NUM_CKPT     = 4
);
  localparam int NA = 2 ** (ARCH_IDX + 1);
  localparam int CW = $clog2(NUM_CKPT);
  localparam int LW = RENAME_WIDTH > 1 ? $clog2(RENAME_WIDTH) : 1;
  logic [RENAME_WIDTH-1:0]               ren_we;
  logic [RENAME_WIDTH-1:0][ARCH_IDX:0]   ren_rs1, ren_rs2, ren_rd;
  logic [RENAME_WIDTH-1:0][PHYS_IDX:0]   ren_pd, ren_ps1, ren_ps2, ren_old_pd;
  logic [RENAME_WIDTH-1:0]               ren_ps1_rdy, ren_ps2_rdy;
  logic [NUM_CDB-1:0]                    cdb_valid;
  logic [NUM_CDB-1:0][PHYS_IDX:0]        cdb_pd;
  logic                                  ckpt_req, ckpt_ack, ckpt_full;
  logic [LW-1:0]                         ckpt_lane;
  logic [CW-1:0]                         ckpt_id, res_id;
  logic                                  res_valid, res_mispredict, flush;
  logic [NA-1:0][PHYS_IDX:0]             rrf_table;
  modport master (
    output ren_we, ren_rs1, ren_rs2, ren_rd, ren_pd, cdb_valid, cdb_pd, ckpt_req, ckpt_lane,
           res_valid, res_id, res_mispredict, flush, rrf_table,
    input  ren_ps1, ren_ps2, ren_ps1_rdy, ren_ps2_rdy, ren_old_pd, ckpt_ack, ckpt_id, ckpt_full
  );
  modport slave (
    input  ren_we, ren_rs1, ren_rs2, ren_rd, ren_pd, cdb_valid, cdb_pd, ckpt_req, ckpt_lane,
           res_valid, res_id, res_mispredict, flush, rrf_table,
    output ren_ps1, ren_ps2, ren_ps1_rdy, ren_ps2_rdy, ren_old_pd, ckpt_ack, ckpt_id, ckpt_full
  );
endinterface

// File: rtl/rat_multi_ckpt.sv
// rat_multi_ckpt: multi-lane register alias table with busy bits and a ring of map checkpoints.
module rat_multi_ckpt #(
  parameter int ARCH_IDX     = 4,
  parameter int PHYS_IDX     = 5,
  parameter int RENAME_WIDTH = 2,
  parameter int NUM_CDB      = 2,
  parameter int NUM_CKPT     = 4
) (
  input logic  clk,
  input logic  rst_n,
  rat_if.slave bus
);
  localparam int NA = 2 ** (ARCH_IDX + 1);
  localparam int NP = 2 ** (PHYS_IDX + 1);
  localparam int W  = RENAME_WIDTH;
  localparam int CW = $clog2(NUM_CKPT);
  typedef logic [PHYS_IDX:0] pr_t;
  typedef pr_t [NA-1:0] map_t;
  map_t map_q, m_c;
  map_t snap_q [NUM_CKPT];
  map_t stage [W];
  logic [NP-1:0] busy_q, busy_nx;
  logic [CW-1:0] head_q, tail_q;
  logic [CW:0] count_q;
  logic [NUM_CKPT-1:0] done_q;
  logic mis, full, ack, retire;
  pr_t p1 [W];
  pr_t p2 [W];
  logic b1 [W];
  logic b2 [W];

  assign mis    = bus.res_valid & bus.res_mispredict;
  assign full   = count_q == (CW+1)'(NUM_CKPT);
  assign ack    = bus.ckpt_req & ~full & ~mis & ~bus.flush;
  assign retire = count_q != '0 && done_q[head_q];
  assign bus.ckpt_ack  = ack;
  assign bus.ckpt_id   = tail_q;
  assign bus.ckpt_full = full;

  function automatic logic cdb_hit(input pr_t p);
    cdb_hit = 1'b0;
    for (int c = 0; c < NUM_CDB; c++)
      if (bus.cdb_valid[c] && bus.cdb_pd[c] == p) cdb_hit = 1'b1;
  endfunction

  // Older lanes in the same group shadow the map; the youngest older writer wins.
  always_comb begin
    for (int j = 0; j < W; j++) begin
      p1[j] = map_q[bus.ren_rs1[j]];
      p2[j] = map_q[bus.ren_rs2[j]];
      b1[j] = 1'b0;
      b2[j] = 1'b0;
      bus.ren_old_pd[j] = map_q[bus.ren_rd[j]];
      for (int k = 0; k < j; k++) begin
        if (bus.ren_we[k] && bus.ren_rd[k] != '0) begin
          if (bus.ren_rd[k] == bus.ren_rs1[j]) begin
            p1[j] = bus.ren_pd[k];
            b1[j] = 1'b1;
          end
          if (bus.ren_rd[k] == bus.ren_rs2[j]) begin
            p2[j] = bus.ren_pd[k];
            b2[j] = 1'b1;
          end
          if (bus.ren_rd[k] == bus.ren_rd[j]) bus.ren_old_pd[j] = bus.ren_pd[k];
        end
      end
      if (bus.ren_rs1[j] == '0) begin
        p1[j] = '0;
        b1[j] = 1'b0;
      end
      if (bus.ren_rs2[j] == '0) begin
        p2[j] = '0;
        b2[j] = 1'b0;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < W; j++) begin
      bus.ren_ps1[j]     = p1[j];
      bus.ren_ps2[j]     = p2[j];
      bus.ren_ps1_rdy[j] = ~b1[j] & (~busy_q[p1[j]] | cdb_hit(p1[j]));
      bus.ren_ps2_rdy[j] = ~b2[j] & (~busy_q[p2[j]] | cdb_hit(p2[j]));
    end
  end

  // stage[k] is the map after lanes 0..k, used both for the update and for partial snapshots.
  always_comb begin
    m_c = map_q;
    for (int k = 0; k < W; k++) begin
      if (bus.ren_we[k] && bus.ren_rd[k] != '0) m_c[bus.ren_rd[k]] = bus.ren_pd[k];
      stage[k] = m_c;
    end
  end

  always_comb begin
    busy_nx = busy_q;
    for (int c = 0; c < NUM_CDB; c++)
      if (bus.cdb_valid[c]) busy_nx[bus.cdb_pd[c]] = 1'b0;
    if (!mis)
      for (int k = 0; k < W; k++)
        if (bus.ren_we[k] && bus.ren_rd[k] != '0) busy_nx[bus.ren_pd[k]] = 1'b1;
    busy_nx[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NA; i++) map_q[i] <= pr_t'(i);
      busy_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      done_q  <= '0;
    end else if (bus.flush) begin
      map_q   <= bus.rrf_table;
      busy_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      done_q  <= '0;
    end else if (mis) begin
      map_q   <= snap_q[bus.res_id];
      busy_q  <= busy_nx;
      tail_q  <= bus.res_id + 1'b1;
      count_q <= {1'b0, CW'(bus.res_id - head_q + 1'b1)};
    end else begin
      map_q  <= stage[W-1];
      busy_q <= busy_nx;
      if (ack) begin
        done_q[tail_q] <= 1'b0;
        tail_q <= tail_q + 1'b1;
      end
      if (bus.res_valid) done_q[bus.res_id] <= 1'b1;
      if (retire) head_q <= head_q + 1'b1;
      count_q <= count_q + (CW+1)'(ack) - (CW+1)'(retire);
    end
  end

  always_ff @(posedge clk)
    if (ack) snap_q[tail_q] <= stage[bus.ckpt_lane];
endmodule

// File: tb/tb_rat_multi_ckpt.sv
// tb_rat_multi_ckpt: directed stimulus with a cycle-tagged expectation queue checked by a separate monitor.
module tb_rat_multi_ckpt;
  logic clk = 1'b0;
  logic rst_n;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  localparam int PS1 = 0, RDY1 = 2, PS2 = 4, RDY2 = 6, OLD = 8, ACK = 10, ID = 11, FULL = 12;
  typedef struct {
    int    cyc;
    int    fld;
    int    val;
    string name;
  } exp_t;
  exp_t q[$];

  rat_if bus ();
  rat_multi_ckpt dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] obs(input int f);
    case (f)
      0:  obs = 32'(bus.ren_ps1[0]);
      1:  obs = 32'(bus.ren_ps1[1]);
      2:  obs = 32'(bus.ren_ps1_rdy[0]);
      3:  obs = 32'(bus.ren_ps1_rdy[1]);
      4:  obs = 32'(bus.ren_ps2[0]);
      5:  obs = 32'(bus.ren_ps2[1]);
      6:  obs = 32'(bus.ren_ps2_rdy[0]);
      7:  obs = 32'(bus.ren_ps2_rdy[1]);
      8:  obs = 32'(bus.ren_old_pd[0]);
      9:  obs = 32'(bus.ren_old_pd[1]);
      10: obs = 32'(bus.ckpt_ack);
      11: obs = 32'(bus.ckpt_id);
      12: obs = 32'(bus.ckpt_full);
      default: obs = '1;
    endcase
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    logic [31:0] a;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      a = obs(e.fld);
      total++;
      if (a !== 32'(e.val) || e.cyc != cyc) begin
        bad++;
        $display("FAIL %s: got %0d want %0d (cycle %0d)", e.name, a, e.val, cyc);
      end
    end
  end

  task automatic chk(input int f, input int v, input string n);
    q.push_back('{cyc, f, v, n});
  endtask

  task automatic idle();
    bus.ren_we = '0;
    bus.ren_rs1 = '0;
    bus.ren_rs2 = '0;
    bus.ren_rd = '0;
    bus.ren_pd = '0;
    bus.cdb_valid = '0;
    bus.cdb_pd = '0;
    bus.ckpt_req = 1'b0;
    bus.ckpt_lane = '0;
    bus.res_valid = 1'b0;
    bus.res_id = '0;
    bus.res_mispredict = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    for (int i = 0; i < 32; i++) bus.rrf_table[i] = 6'(i);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    bus.ren_rs1[0] = 5; bus.ren_rs2[0] = 0;
    chk(PS1, 5, "rst_ps1"); chk(RDY1, 1, "rst_rdy1"); chk(PS2, 0, "rst_ps2_zero");
    chk(RDY2, 1, "rst_rdy2_zero"); chk(FULL, 0, "rst_full"); chk(ID, 0, "rst_id");
    step();
    bus.ren_we = 2'b11; bus.ren_rd[0] = 3; bus.ren_pd[0] = 40;
    bus.ren_rs1[1] = 3; bus.ren_rd[1] = 3; bus.ren_pd[1] = 41;
    chk(PS1+1, 40, "byp_ps1"); chk(RDY1+1, 0, "byp_rdy"); chk(OLD+1, 40, "byp_old");
    chk(OLD, 3, "lane0_old");
    step();
    bus.ren_rs1[0] = 3; bus.cdb_valid = 2'b10; bus.cdb_pd[1] = 41;
    chk(PS1, 41, "youngest_wins"); chk(RDY1, 1, "cdb_same_cycle");
    step();
    bus.ren_rs1[0] = 3; bus.ren_we = 2'b01; bus.ren_rd[0] = 8; bus.ren_pd[0] = 50;
    chk(PS1, 41, "map3_kept"); chk(RDY1, 1, "busy_cleared");
    step();
    bus.ren_rs1[0] = 8; bus.cdb_valid = 2'b01; bus.cdb_pd[0] = 50;
    bus.ren_we = 2'b01; bus.ren_rd[0] = 9; bus.ren_pd[0] = 50;
    chk(PS1, 50, "map8"); chk(RDY1, 1, "cdb_bypass_rdy");
    step();
    bus.ren_rs1[0] = 9; bus.ren_rs1[1] = 8;
    chk(PS1, 50, "map9"); chk(RDY1, 0, "set_beats_clear");
    chk(PS1+1, 50, "map8_l1"); chk(RDY1+1, 0, "busy50_l1");
    for (int k = 0; k < 4; k++) begin
      step();
      bus.ckpt_req = 1'b1;
      chk(ACK, 1, "fill_ack"); chk(ID, k, "fill_id"); chk(FULL, 0, "fill_full");
    end
    step();
    bus.ckpt_req = 1'b1; bus.res_valid = 1'b1; bus.res_id = 1;
    chk(FULL, 1, "full"); chk(ACK, 0, "full_noack");
    step();
    bus.res_valid = 1'b1; bus.res_id = 0;
    chk(FULL, 1, "no_retire_id1");
    step();
    chk(FULL, 1, "retire_pending");
    step();
    bus.ckpt_req = 1'b1;
    chk(FULL, 0, "retired_one"); chk(ACK, 1, "wrap_ack"); chk(ID, 0, "wrap_id");
    step();
    chk(FULL, 0, "retired_two"); chk(ID, 1, "tail_one");
    step();
    rst_n = 1'b0;
    bus.ren_rs1[0] = 3;
    chk(ID, 0, "async_rst_id"); chk(FULL, 0, "async_rst_full");
    chk(PS1, 3, "async_rst_map"); chk(RDY1, 1, "async_rst_rdy");
    step();
    rst_n = 1'b1;
    bus.ren_we = 2'b01; bus.ren_rd[0] = 3; bus.ren_pd[0] = 40;
    step();
    bus.ren_we = 2'b11; bus.ren_rd[0] = 4; bus.ren_pd[0] = 44; bus.ren_rd[1] = 3; bus.ren_pd[1] = 41;
    bus.ckpt_req = 1'b1; bus.ckpt_lane = 0;
    chk(ACK, 1, "ck0_ack"); chk(ID, 0, "ck0_id");
    step();
    bus.ren_we = 2'b01; bus.ren_rd[0] = 5; bus.ren_pd[0] = 45;
    bus.ckpt_req = 1'b1; bus.ckpt_lane = 1;
    chk(ACK, 1, "ck1_ack"); chk(ID, 1, "ck1_id");
    step();
    bus.res_valid = 1'b1; bus.res_mispredict = 1'b1; bus.res_id = 0;
    bus.ckpt_req = 1'b1; bus.ren_we = 2'b01; bus.ren_rd[0] = 3; bus.ren_pd[0] = 46;
    bus.cdb_valid = 2'b01; bus.cdb_pd[0] = 41; bus.ren_rs1[0] = 3;
    chk(PS1, 41, "pre_mis_map"); chk(ACK, 0, "mis_drops_req");
    step();
    bus.ren_rs1[0] = 3; bus.ren_rs2[0] = 4; bus.ren_rs1[1] = 5; bus.ren_rs2[1] = 3;
    bus.ckpt_req = 1'b1;
    chk(PS1, 40, "restored_r3"); chk(RDY1, 0, "restored_busy40"); chk(PS2, 44, "restored_r4");
    chk(PS1+1, 5, "restored_r5"); chk(RDY1+1, 1, "restored_r5_rdy");
    chk(PS2+1, 40, "rename_dropped"); chk(RDY2+1, 0, "rename_dropped_rdy");
    chk(ACK, 1, "post_mis_ack"); chk(ID, 1, "post_mis_tail");
    step();
    bus.ckpt_req = 1'b1;
    chk(ID, 2, "post_mis_id2");
    step();
    bus.ckpt_req = 1'b1;
    chk(ID, 3, "post_mis_id3"); chk(FULL, 0, "count_was_one");
    step();
    bus.ckpt_req = 1'b1;
    chk(FULL, 1, "post_mis_full"); chk(ACK, 0, "post_mis_noack");
    step();
    bus.flush = 1'b1; bus.res_valid = 1'b1; bus.res_mispredict = 1'b1; bus.res_id = 2;
    bus.ckpt_req = 1'b1; bus.rrf_table[3] = 7; bus.rrf_table[5] = 40;
    chk(ACK, 0, "flush_noack"); chk(FULL, 1, "pre_flush_full");
    step();
    bus.ren_rs1[0] = 3; bus.ren_rs2[0] = 4; bus.ren_rs2[1] = 5; bus.ckpt_req = 1'b1;
    chk(PS1, 7, "flush_r3"); chk(RDY1, 1, "flush_r3_rdy"); chk(PS2, 4, "flush_r4");
    chk(PS2+1, 40, "flush_r5"); chk(RDY2+1, 1, "flush_busy_clr");
    chk(FULL, 0, "flush_full"); chk(ACK, 1, "flush_ack"); chk(ID, 0, "flush_id");
    step();
    step();
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
